// File: rtl/dds_nco.sv
// Multi-channel sin/cos NCO time-sharing one quarter-wave sine SRAM port.
// Each accepted tick advances every accumulator, issues 2*N_CH reads, then commits all channels at once.
module dds_nco #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned LUT_AW  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       sync,
    input  logic [N_CH*PHASE_W-1:0]    ftw,
    input  logic [N_CH*(LUT_AW+2)-1:0] poff,
    output logic [LUT_AW-1:0]          addr,
    input  logic [DATA_W-1:0]          data,
    output logic [N_CH*DATA_W-1:0]     sin_out,
    output logic [N_CH*DATA_W-1:0]     cos_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       overrun
);
    localparam int unsigned PH_W  = LUT_AW + 2;
    localparam int unsigned N_RD  = 2 * N_CH;
    localparam int unsigned CNT_W = $clog2(N_RD);
    localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   acc_q   [N_CH];
    logic [PHASE_W-1:0]   acc_d   [N_CH];
    logic [PH_W-1:0]      poff_q  [N_CH];
    logic [PH_W-1:0]      poff_d  [N_CH];
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [DRN_W-1:0]     drn_cnt_q, drn_cnt_d;
    logic [LUT_AW-1:0]    addr_q, addr_d;
    logic                 tag_vld_q [RD_LAT];
    logic                 tag_vld_d [RD_LAT];
    logic [CNT_W-1:0]     tag_idx_q [RD_LAT];
    logic [CNT_W-1:0]     tag_idx_d [RD_LAT];
    logic                 tag_neg_q [RD_LAT];
    logic                 tag_neg_d [RD_LAT];
    logic [DATA_W-1:0]    shd_q     [N_RD];
    logic [DATA_W-1:0]    shd_d     [N_RD];
    logic [N_CH*DATA_W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ovr_q, ovr_d;

    logic [PH_W-1:0]      ph_c [N_CH];
    logic [PH_W-1:0]      ph_sel_c;
    logic [1:0]           quad_c;
    logic [LUT_AW-1:0]    idx_c;
    logic [LUT_AW-1:0]    rd_addr_c;
    logic                 rd_neg_c;

    // Per-channel table phase from the post-tick accumulator and latched offset.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ph_c[c] = acc_q[c][PHASE_W-1 -: PH_W] + poff_q[c];
        end
    end

    // Quadrant fold for the read being issued; even reads are sin, odd reads are cos.
    always_comb begin
        ph_sel_c = '0;
        for (int c = 0; c < N_CH; c++) begin
            if ((rd_cnt_q >> 1) == CNT_W'(c)) begin
                ph_sel_c = ph_c[c];
            end
        end
        quad_c = ph_sel_c[PH_W-1 -: 2];
        idx_c  = ph_sel_c[LUT_AW-1:0];
        if (rd_cnt_q[0]) begin
            rd_addr_c = quad_c[0] ? idx_c : ~idx_c;
            rd_neg_c  = quad_c[1] ^ quad_c[0];
        end else begin
            rd_addr_c = quad_c[0] ? ~idx_c : idx_c;
            rd_neg_c  = quad_c[1];
        end
    end

    // Next-state, read tagging, shadow capture and commit.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        poff_d    = poff_q;
        rd_cnt_d  = rd_cnt_q;
        drn_cnt_d = drn_cnt_q;
        addr_d    = addr_q;
        shd_d     = shd_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        ovr_d     = ovr_q;

        tag_vld_d[0] = 1'b0;
        tag_idx_d[0] = rd_cnt_q;
        tag_neg_d[0] = rd_neg_c;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
            tag_neg_d[i] = tag_neg_q[i-1];
        end

        if (tag_vld_q[RD_LAT-1]) begin
            for (int k = 0; k < N_RD; k++) begin
                if (tag_idx_q[RD_LAT-1] == CNT_W'(k)) begin
                    shd_d[k] = tag_neg_q[RD_LAT-1] ? ~data : data;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    for (int c = 0; c < N_CH; c++) begin
                        acc_d[c]  = sync ? '0 : acc_q[c] + ftw[c*PHASE_W +: PHASE_W];
                        poff_d[c] = poff[c*PH_W +: PH_W];
                    end
                    rd_cnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                addr_d       = rd_addr_c;
                tag_vld_d[0] = 1'b1;
                if (rd_cnt_q == CNT_W'(N_RD - 1)) begin
                    drn_cnt_d = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (tick) begin
                    ovr_d = 1'b1;
                end
                if (drn_cnt_q == DRN_W'(RD_LAT - 1)) begin
                    // Last word lands in the shadow on this same edge, so commit from shd_d.
                    for (int c = 0; c < N_CH; c++) begin
                        sin_d[c*DATA_W +: DATA_W] = shd_d[2*c];
                        cos_d[c*DATA_W +: DATA_W] = shd_d[2*c+1];
                    end
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    drn_cnt_d = drn_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            drn_cnt_q <= '0;
            addr_q    <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c]  <= '0;
                poff_q[c] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
                tag_neg_q[i] <= 1'b0;
            end
            for (int k = 0; k < N_RD; k++) begin
                shd_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            addr_q    <= addr_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            acc_q     <= acc_d;
            poff_q    <= poff_d;
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
            tag_neg_q <= tag_neg_d;
            shd_q     <= shd_d;
        end
    end

    assign addr    = addr_q;
    assign sin_out = sin_q;
    assign cos_out = cos_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_dds_nco.sv
// Bench for dds_nco: table model data[a]=a, reference sine model with cos(p)=sin(p+quarter), scoreboard on valid.
module tb_dds_nco;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned LUT_AW  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned PH_W    = LUT_AW + 2;
    localparam int unsigned LAT     = 2*N_CH + RD_LAT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic sync = 1'b0;
    logic [N_CH*PHASE_W-1:0] ftw = '0;
    logic [N_CH*PH_W-1:0]    poff = '0;
    logic [LUT_AW-1:0]       addr;
    logic [DATA_W-1:0]       data;
    logic [N_CH*DATA_W-1:0]  sin_out, cos_out;
    logic valid, busy, overrun;

    dds_nco #(
        .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W), .N_CH(N_CH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .sync(sync), .ftw(ftw), .poff(poff),
        .addr(addr), .data(data), .sin_out(sin_out), .cos_out(cos_out),
        .valid(valid), .busy(busy), .overrun(overrun)
    );

    // The registered addr is the SRAM input stage, so a one-clock table reads combinationally here.
    assign data = DATA_W'(addr);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                     due;
        logic [N_CH*DATA_W-1:0] s;
        logic [N_CH*DATA_W-1:0] c;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               mon_e;
    logic [PHASE_W-1:0] m_acc [N_CH];
    int                 checks = 0;
    int                 errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Full-wave sine from a quarter table holding a at address a.
    function automatic logic [DATA_W-1:0] m_sin(input logic [PH_W-1:0] p);
        logic [1:0]        q;
        logic [LUT_AW-1:0] a;
        q = p[PH_W-1 -: 2];
        a = p[LUT_AW-1:0];
        if (q == 2'd1 || q == 2'd3) a = {LUT_AW{1'b1}} - a;
        return (q >= 2'd2) ? ~DATA_W'(a) : DATA_W'(a);
    endfunction

    task automatic set_ch(input int c, input logic [PHASE_W-1:0] f, input logic [PH_W-1:0] po);
        ftw[c*PHASE_W +: PHASE_W] = f;
        poff[c*PH_W +: PH_W]      = po;
    endtask

    task automatic issue_tick(input bit s);
        exp_t            e;
        logic [PH_W-1:0] p;
        @(negedge clk);
        tick = 1'b1;
        sync = s;
        for (int c = 0; c < N_CH; c++) begin
            m_acc[c] = s ? '0 : m_acc[c] + ftw[c*PHASE_W +: PHASE_W];
            p = PH_W'(m_acc[c] >> (PHASE_W - PH_W)) + poff[c*PH_W +: PH_W];
            e.s[c*DATA_W +: DATA_W] = m_sin(p);
            e.c[c*DATA_W +: DATA_W] = m_sin(p + PH_W'(1 << LUT_AW));
        end
        e.due = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(negedge clk);
        tick = 1'b0;
        sync = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL valid_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"}, 64'(addr), 64'h0);
        chk({tag, "_sin"}, 64'(sin_out), 64'h0);
        chk({tag, "_cos"}, 64'(cos_out), 64'h0);
        chk({tag, "_valid"}, 64'(valid), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_overrun"}, 64'(overrun), 64'h0);
    endtask

    task automatic quadrant0(input string tag);
        set_ch(0, '0, PH_W'(18'h00005));
        set_ch(1, '0, '0);
        issue_tick(1'b1);
        chk({tag, "_busy_e0"}, 64'(busy), 64'h1);
        @(negedge clk);
        chk({tag, "_addr_e1"}, 64'(addr), 64'h0005);
        @(negedge clk);
        chk({tag, "_addr_e2"}, 64'(addr), 64'hFFFA);
        wait_done();
        chk({tag, "_sin0"}, 64'(sin_out[DATA_W-1:0]), 64'h0005);
        chk({tag, "_cos0"}, 64'(cos_out[DATA_W-1:0]), 64'hFFFA);
        chk({tag, "_busy_done"}, 64'(busy), 64'h0);
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expected set and its due cycle.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(mon_e.due));
                chk("sin_out", 64'(sin_out), 64'(mon_e.s));
                chk("cos_out", 64'(cos_out), 64'(mon_e.c));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int gap;
        for (int c = 0; c < N_CH; c++) m_acc[c] = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;

        quadrant0("q0");

        set_ch(0, '0, PH_W'(18'h10005));
        issue_tick(1'b1);
        wait_done();
        chk("q1_sin0", 64'(sin_out[DATA_W-1:0]), 64'hFFFA);
        chk("q1_cos0", 64'(cos_out[DATA_W-1:0]), 64'hFFFA);

        set_ch(0, '0, PH_W'(18'h30005));
        issue_tick(1'b1);
        wait_done();
        chk("q3_sin0", 64'(sin_out[DATA_W-1:0]), 64'h0005);
        chk("q3_cos0", 64'(cos_out[DATA_W-1:0]), 64'h0005);

        set_ch(0, 32'h8000_0000, '0);
        set_ch(1, 32'h4000_0000, '0);
        issue_tick(1'b1);
        wait_done();
        chk("wrap0_sin", 64'(sin_out), 64'h0000_0000);
        chk("wrap0_cos", 64'(cos_out), 64'hFFFF_FFFF);
        issue_tick(1'b0);
        wait_done();
        chk("wrap1_sin", 64'(sin_out), 64'hFFFF_FFFF);
        chk("wrap1_cos", 64'(cos_out), 64'hFFFF_0000);
        issue_tick(1'b0);
        wait_done();
        chk("wrap2_sin0", 64'(sin_out[DATA_W-1:0]), 64'h0000);
        chk("wrap2_cos0", 64'(cos_out[DATA_W-1:0]), 64'hFFFF);

        set_ch(0, 32'h1234_5678, PH_W'(18'h0ABCD));
        issue_tick(1'b0);
        @(negedge clk);
        set_ch(0, 32'h0F0F_0F0F, PH_W'(18'h2F00F));
        set_ch(1, 32'h7654_3210, PH_W'(18'h15555));
        wait_done();
        issue_tick(1'b0);
        wait_done();

        chk("ovr_before", 64'(overrun), 64'h0);
        issue_tick(1'b0);
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("ovr_set", 64'(overrun), 64'h1);
        chk("ovr_busy", 64'(busy), 64'h1);
        wait_done();
        repeat (4) @(negedge clk);
        chk("ovr_sticky", 64'(overrun), 64'h1);
        issue_tick(1'b0);
        wait_done();

        issue_tick(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        for (int c = 0; c < N_CH; c++) m_acc[c] = '0;
        @(negedge clk);
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_valid", 64'(valid), 64'h0);
        quadrant0("q0b");

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N_CH; c++) set_ch(c, PHASE_W'($urandom), PH_W'($urandom));
            issue_tick($urandom_range(0, 7) == 0);
            gap = $urandom_range(4, 7);
            repeat (gap) begin
                @(negedge clk);
                for (int c = 0; c < N_CH; c++) set_ch(c, PHASE_W'($urandom), PH_W'($urandom));
            end
        end
        wait_done();
        chk("rand_no_overrun", 64'(overrun), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_nco.md
# dds_nco

Multi-channel, parametrised sin/cos NCO that time-multiplexes one synchronous quarter-wave sine SRAM across N_CH channels. Each channel has its own phase accumulator, frequency tuning word and phase offset. On every sample `tick`, every channel advances, and the block reads sin and cos for each channel through the shared SRAM port. All channel outputs are then committed together under one `valid` pulse. It sits between the sample-rate timebase and the lock-in mixers, and replaces single-channel, externally-phased lookup.

## Interface
- PHASE_W, 32: accumulator width; must be >= LUT_AW+2.
- LUT_AW, 16: quarter-table address width.
- DATA_W, 16: table/output sample width.
- N_CH, 2: channel count, >= 1.
- RD_LAT, 1: SRAM read latency in clocks (>= 1), from registered `addr` to sampled `data`.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle sample strobe; starts a conversion when idle.
- sync  in  1  sampled with `tick`; 1 = load all accumulators with 0 instead of adding FTW.
- ftw  in  N_CH*PHASE_W  per-channel tuning word; channel c occupies bits [c*PHASE_W +: PHASE_W].
- poff  in  N_CH*(LUT_AW+2)  per-channel phase offset, same packing.
- addr  out  LUT_AW  registered SRAM address.
- data  in  DATA_W  SRAM read data.
- sin_out, cos_out  out  N_CH*DATA_W  registered results, channel-packed.
- valid  out  1  one-cycle pulse when a new result set is committed.
- busy  out  1  conversion in progress.
- overrun  out  1  sticky flag; set by a `tick` while busy, cleared only by reset.

## Operation
- **States:**
  - IDLE -> ISSUE on `tick`.
  - ISSUE issues 2*N_CH addresses, one per clock.
  - ISSUE -> DRAIN after the last address; DRAIN waits RD_LAT cycles, then commits and returns to IDLE.
- **At the `tick` edge:**
  - acc[c] <= sync ? 0 : acc[c]+ftw[c] for every channel, modulo 2^PHASE_W.
  - ftw and poff are latched; later changes do not affect this conversion.
- **Phase:** p[c] = acc[c][PHASE_W-1 -: LUT_AW+2] + poff[c], modulo 2^(LUT_AW+2). Computed from the post-update accumulator.
- **Fold:** q = p[top 2 bits], idx = p[LUT_AW-1:0].
  - sin address = q[0] ? ~idx : idx.
  - cos address = q[0] ? idx : ~idx.
- **Sign:**
  - sin = q[1] ? ~data : data.
  - cos = (q[1]^q[0]) ? ~data : data.
  - Negation is one's complement, matching the table convention.
- **Issue order:** ch0 sin, ch0 cos, ch1 sin, ..., ch(N-1) cos.
- **Capture and commit:**
  - Each `data` word is captured into a shadow register RD_LAT cycles after its address.
  - sin_out/cos_out load from the shadow registers simultaneously with `valid`, so consumers never see a mixed set.
- **Idle:** `addr` holds its last value.
- **Overrun:** a `tick` while busy is ignored (no accumulator update) and sets `overrun`.
- **Reset (async, any time):**
  - acc, addr, sin_out, cos_out and shadow registers go to 0; valid, busy and overrun go to 0; state goes to IDLE.
  - Reset mid-conversion aborts with no `valid`.

## Timing
- `tick` sampled at edge E0; accumulators and latches update at E0.
- `busy` is 1 from E0 until the commit edge, and 0 in the cycle after it.
- Addresses are driven at edges E1..E(2*N_CH).
- Last data is captured and outputs committed at edge E(2*N_CH+RD_LAT); `valid` is high for exactly that following cycle.
- Latency: 2*N_CH+RD_LAT clocks (5 for defaults).
- A `tick` in the cycle after the commit (busy=0) is accepted. Minimum tick period is 2*N_CH+RD_LAT+1.

## Test plan
Bench SRAM model: data[a]=a, RD_LAT=1, defaults otherwise.
- **Quadrant 0:** reset, then ch0 poff=0x00005, sync=1, tick -> addr E1=0x0005, E2=0xFFFA; sin0=0x0005, cos0=0xFFFA; valid for one cycle at edge 5.
- **Quadrants 1 and 3:**
  - poff=0x10005 -> sin0=0xFFFA, cos0=0xFFFA.
  - poff=0x30005 -> sin0=0x0005, cos0=0x0005.
- **Wrap and two channels:**
  - Setup: ftw0=0x8000_0000, ftw1=0x4000_0000, poff=0.
  - sync tick -> both channels give sin=0x0000, cos=0xFFFF.
  - Next tick -> ch0 sin=0xFFFF, cos=0x0000 (q=2); ch1 sin=0xFFFF, cos=0xFFFF (q=1).
  - Next tick -> ch0 wraps back to sin=0x0000, cos=0xFFFF.
- **Latched inputs:** change ftw/poff at E2 -> current results unchanged; the next tick uses the new values.
- **Overrun:** tick at E0 and E3 -> exactly one valid at E5; overrun=1 from E3 and held; acc advanced once.
- **Mid-conversion reset:** assert rst_n=0 at E3 -> outputs 0, busy=0, no valid; a fresh tick after release behaves as in the quadrant 0 test.
